// File: rtl/priv_1_12_debug_ctrl.sv
// Debug halt/resume/single-step sequencer for the 1.12 privilege unit.
// Drains the pipeline, latches dpc/cause, and pulses debug-mode entry/exit.
module priv_1_12_debug_ctrl #(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        haltreq,
  input  logic        resumereq,
  input  logic        ebreak_dmode,
  input  logic [31:0] ebreak_pc,
  input  logic        dcsr_step,
  input  logic        pipe_idle,
  input  logic        commit_valid,
  input  logic [31:0] next_pc,
  output logic        stall_fetch,
  output logic        enter_dmode,
  output logic        exit_dmode,
  output logic        dpc_wen,
  output logic [31:0] dpc_wdata,
  output logic [2:0]  dcsr_cause,
  output logic        halted,
  output logic        resumeack,
  output logic        drain_timeout
);

  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);

  localparam logic [2:0] RUNNING    = 3'd0;
  localparam logic [2:0] DRAIN      = 3'd1;
  localparam logic [2:0] HALT_ENTER = 3'd2;
  localparam logic [2:0] HALTED     = 3'd3;
  localparam logic [2:0] RESUME     = 3'd4;
  localparam logic [2:0] STEP       = 3'd5;

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    cause_q;
  logic [31:0]   dpc_q;
  logic          timeout_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUNNING;
      cnt       <= '0;
      cause_q   <= '0;
      dpc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUNNING: begin
          if (ebreak_dmode) begin
            state   <= HALT_ENTER;
            cause_q <= CAUSE_EBREAK;
            dpc_q   <= ebreak_pc;
          end else if (haltreq) begin
            state   <= DRAIN;
            cause_q <= CAUSE_HALTREQ;
            cnt     <= '0;
          end
        end
        DRAIN: begin
          // A committed debug ebreak supersedes whatever caused the drain.
          if (ebreak_dmode) begin
            state   <= HALT_ENTER;
            cause_q <= CAUSE_EBREAK;
            dpc_q   <= ebreak_pc;
          end else if (pipe_idle) begin
            state <= HALT_ENTER;
            dpc_q <= next_pc;
          end else if (cnt == CNT_LAST) begin
            state     <= HALT_ENTER;
            dpc_q     <= next_pc;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HALT_ENTER: state <= HALTED;
        HALTED: begin
          if (resumereq) state <= RESUME;
        end
        RESUME: state <= dcsr_step ? STEP : RUNNING;
        STEP: begin
          if (ebreak_dmode) begin
            state   <= HALT_ENTER;
            cause_q <= CAUSE_EBREAK;
            dpc_q   <= ebreak_pc;
          end else if (haltreq) begin
            state   <= DRAIN;
            cause_q <= CAUSE_HALTREQ;
            cnt     <= '0;
          end else if (commit_valid) begin
            state   <= DRAIN;
            cause_q <= CAUSE_STEP;
            cnt     <= '0;
          end
        end
        default: state <= RUNNING;
      endcase
    end
  end

  // The hart stays in debug mode through the RESUME cycle; the flag clears on its exit edge.
  assign stall_fetch   = (state == DRAIN) || (state == HALT_ENTER) ||
                         (state == HALTED) || (state == RESUME);
  assign enter_dmode   = (state == HALT_ENTER);
  assign dpc_wen       = (state == HALT_ENTER);
  assign exit_dmode    = (state == RESUME);
  assign resumeack     = (state == RESUME);
  assign halted        = (state == HALTED) || (state == RESUME);
  assign dpc_wdata     = dpc_q;
  assign dcsr_cause    = cause_q;
  assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_priv_1_12_debug_ctrl.sv
// Bench for priv_1_12_debug_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the sequencer.
module tb_priv_1_12_debug_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, haltreq, resumereq, ebreak_dmode, dcsr_step, pipe_idle, commit_valid;
  logic [31:0] ebreak_pc, next_pc;
  logic        stall_fetch, enter_dmode, exit_dmode, dpc_wen, halted, resumeack, drain_timeout;
  logic [31:0] dpc_wdata;
  logic [2:0]  dcsr_cause;

  int n_tests = 0;
  int n_fail  = 0;
  int enter_cnt = 0;
  int exit_cnt  = 0;

  always #5 clk = ~clk;

  priv_1_12_debug_ctrl #(.DRAIN_TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst), .haltreq(haltreq), .resumereq(resumereq),
    .ebreak_dmode(ebreak_dmode), .ebreak_pc(ebreak_pc), .dcsr_step(dcsr_step),
    .pipe_idle(pipe_idle), .commit_valid(commit_valid), .next_pc(next_pc),
    .stall_fetch(stall_fetch), .enter_dmode(enter_dmode), .exit_dmode(exit_dmode),
    .dpc_wen(dpc_wen), .dpc_wdata(dpc_wdata), .dcsr_cause(dcsr_cause),
    .halted(halted), .resumeack(resumeack), .drain_timeout(drain_timeout)
  );

  // Model: where the hart is in the halt/resume story, expressed as flags.
  bit          m_in_debug;     // parked in debug mode waiting for resume
  bit          m_entering;     // this cycle is the debug-entry pulse
  bit          m_leaving;      // this cycle is the resume/dret pulse
  bit          m_draining;
  bit          m_stepping;
  int          m_drained;      // DRAIN cycles elapsed
  logic [2:0]  m_cause;
  logic [31:0] m_dpc;
  bit          m_timeout;

  function automatic void m_clear();
    m_in_debug = 0; m_entering = 0; m_leaving = 0; m_draining = 0; m_stepping = 0;
    m_drained = 0;
  endfunction

  function automatic void m_go_enter(logic [2:0] c, bit set_c, logic [31:0] pc);
    m_clear();
    m_entering = 1;
    if (set_c) m_cause = c;
    m_dpc = pc;
  endfunction

  function automatic void m_go_drain(logic [2:0] c);
    m_clear();
    m_draining = 1;
    m_cause = c;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  function automatic void m_edge();
    if (rst) begin
      m_clear(); m_cause = 0; m_dpc = 0; m_timeout = 0;
    end else if (m_entering) begin
      m_clear(); m_in_debug = 1;
    end else if (m_leaving) begin
      bit s = dcsr_step;
      m_clear(); m_stepping = s;
    end else if (m_in_debug) begin
      if (resumereq) begin m_clear(); m_leaving = 1; end
    end else if (m_draining) begin
      m_drained++;
      if (ebreak_dmode) m_go_enter(3'd1, 1, ebreak_pc);
      else if (pipe_idle) m_go_enter(3'd0, 0, next_pc);
      else if (m_drained == TMO) begin
        m_timeout = 1;
        m_go_enter(3'd0, 0, next_pc);
      end
    end else if (m_stepping) begin
      if (ebreak_dmode) m_go_enter(3'd1, 1, ebreak_pc);
      else if (haltreq) m_go_drain(3'd3);
      else if (commit_valid) m_go_drain(3'd4);
    end else begin
      if (ebreak_dmode) m_go_enter(3'd1, 1, ebreak_pc);
      else if (haltreq) m_go_drain(3'd3);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("stall_fetch", {31'd0, stall_fetch},
        {31'd0, m_draining | m_entering | m_in_debug | m_leaving});
    chk("enter_dmode", {31'd0, enter_dmode}, {31'd0, m_entering});
    chk("dpc_wen",     {31'd0, dpc_wen},     {31'd0, m_entering});
    chk("exit_dmode",  {31'd0, exit_dmode},  {31'd0, m_leaving});
    chk("resumeack",   {31'd0, resumeack},   {31'd0, m_leaving});
    chk("halted",      {31'd0, halted},      {31'd0, m_in_debug | m_leaving});
    chk("dpc_wdata",   dpc_wdata, m_dpc);
    chk("dcsr_cause",  {29'd0, dcsr_cause}, {29'd0, m_cause});
    chk("drain_timeout", {31'd0, drain_timeout}, {31'd0, m_timeout});
  endtask

  // One clock: model and DUT cross the same edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
    compare_model();
    if (enter_dmode) enter_cnt++;
    if (exit_dmode)  exit_cnt++;
  endtask

  task automatic idle_inputs();
    rst = 0; haltreq = 0; resumereq = 0; ebreak_dmode = 0; dcsr_step = 0;
    pipe_idle = 0; commit_valid = 0; ebreak_pc = 0; next_pc = 0;
  endtask

  task automatic resume(input bit step);
    resumereq = 1; dcsr_step = step;
    tick();
    resumereq = 0;
    tick();
  endtask

  initial begin
    idle_inputs();
    m_clear(); m_cause = 0; m_dpc = 0; m_timeout = 0;
    rst = 1;
    tick(); tick();
    chk("rst_stall", {31'd0, stall_fetch}, 32'd0);
    chk("rst_dpc", dpc_wdata, 32'd0);
    chk("rst_cause", {29'd0, dcsr_cause}, 32'd0);
    rst = 0;
    tick();

    // Halt while the pipe is already idle.
    haltreq = 1; pipe_idle = 1; next_pc = 32'h8000_0010;
    tick();
    chk("idle_drain_no_enter", {31'd0, enter_dmode}, 32'd0);
    tick();
    chk("idle_enter", {31'd0, enter_dmode}, 32'd1);
    chk("idle_dpc", dpc_wdata, 32'h8000_0010);
    chk("idle_cause", {29'd0, dcsr_cause}, 32'd3);
    haltreq = 0;
    tick();
    chk("idle_halted", {31'd0, halted}, 32'd1);
    resumereq = 1;
    tick();
    chk("resume_ack", {31'd0, resumeack}, 32'd1);
    chk("resume_exit", {31'd0, exit_dmode}, 32'd1);
    resumereq = 0;
    tick();
    chk("resume_unhalted", {31'd0, halted}, 32'd0);

    // Debug ebreak, alone and together with haltreq.
    for (int k = 0; k < 2; k++) begin
      ebreak_dmode = 1; ebreak_pc = 32'h200; haltreq = (k == 1);
      tick();
      chk("ebrk_dpc", dpc_wdata, 32'h200);
      chk("ebrk_cause", {29'd0, dcsr_cause}, 32'd1);
      ebreak_dmode = 0; haltreq = 0;
      tick();
      chk("ebrk_halted", {31'd0, halted}, 32'd1);
      resume(0);
    end

    // Drain timeout with the pipe never going idle.
    pipe_idle = 0; haltreq = 1; next_pc = 32'h0000_3000;
    tick();
    haltreq = 0;
    for (int k = 0; k < TMO - 1; k++) tick();
    chk("tmo_not_yet", {31'd0, enter_dmode}, 32'd0);
    tick();
    chk("tmo_enter", {31'd0, enter_dmode}, 32'd1);
    chk("tmo_flag", {31'd0, drain_timeout}, 32'd1);
    chk("tmo_dpc", dpc_wdata, 32'h0000_3000);
    tick();
    resume(0);
    chk("tmo_sticky", {31'd0, drain_timeout}, 32'd1);

    // Single step through one commit.
    ebreak_dmode = 1; ebreak_pc = 32'h100;
    tick();
    ebreak_dmode = 0;
    tick();
    resume(1);
    chk("step_stall_low", {31'd0, stall_fetch}, 32'd0);
    commit_valid = 1; next_pc = 32'h104; pipe_idle = 1;
    tick();
    commit_valid = 0;
    chk("step_stall_high", {31'd0, stall_fetch}, 32'd1);
    tick();
    chk("step_cause", {29'd0, dcsr_cause}, 32'd4);
    chk("step_dpc", dpc_wdata, 32'h104);
    tick();
    chk("step_halted", {31'd0, halted}, 32'd1);

    // Step interrupted by haltreq.
    pipe_idle = 0;
    resume(1);
    enter_cnt = 0;
    haltreq = 1;
    tick();
    haltreq = 0; pipe_idle = 1; next_pc = 32'h108;
    for (int k = 0; k < 4; k++) tick();
    chk("steph_cause", {29'd0, dcsr_cause}, 32'd3);
    chk("steph_one_enter", enter_cnt, 32'd1);
    resume(0);

    // Reset while draining, then while halted.
    pipe_idle = 0; haltreq = 1;
    tick(); tick();
    haltreq = 0; enter_cnt = 0; exit_cnt = 0;
    rst = 1;
    tick();
    chk("rst_drain_stall", {31'd0, stall_fetch}, 32'd0);
    chk("rst_drain_tmo", {31'd0, drain_timeout}, 32'd0);
    rst = 0;
    ebreak_dmode = 1; ebreak_pc = 32'h400;
    tick();
    ebreak_dmode = 0;
    tick();
    enter_cnt = 0;
    rst = 1; resumereq = 1;
    tick();
    chk("rst_halt_dpc", dpc_wdata, 32'd0);
    chk("rst_halt_halted", {31'd0, halted}, 32'd0);
    rst = 0; resumereq = 0;
    tick(); tick();
    chk("rst_no_pulses", enter_cnt + exit_cnt, 32'd0);

    // Random traffic.
    begin
      int idle_pct = 70;
      for (int c = 0; c < 4000; c++) begin
        if (c % 250 == 0) idle_pct = $urandom_range(0, 100);
        rst          = ($urandom_range(0, 299) == 0);
        haltreq      = ($urandom_range(0, 5) == 0);
        resumereq    = ($urandom_range(0, 3) == 0);
        ebreak_dmode = ($urandom_range(0, 15) == 0);
        ebreak_pc    = $urandom;
        dcsr_step    = $urandom_range(0, 1) == 1;
        pipe_idle    = ($urandom_range(0, 99) < idle_pct);
        commit_valid = ($urandom_range(0, 2) == 0);
        next_pc      = $urandom;
        tick();
        chk("no_dual_pulse", {31'd0, enter_dmode & exit_dmode}, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
